// File: rtl/glitch_detector.sv
// glitch_detector: lockstep compare of two redundant copies; filters transients, latches persistent faults.
// Optional GLITCH_DETECTOR_SYNDROME_EN keeps in_a^in_b of each fault's first mismatching beat.
module glitch_detector #(
  parameter int BIT_LENGTH = 8,
  parameter int PERSIST = 2,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  valid,
  input  logic [BIT_LENGTH-1:0] in_a,
  input  logic [BIT_LENGTH-1:0] in_b,
  input  logic                  clear,
  output logic [BIT_LENGTH-1:0] out,
  output logic                  alarm,
  output logic [CNT_W-1:0]      transient_count,
  output logic [CNT_W-1:0]      fault_count,
  output logic [BIT_LENGTH-1:0] syndrome
);
  localparam int PW = $clog2(PERSIST + 1);
  typedef enum logic [1:0] {IDLE, MONITOR, SUSPECT, ALARM} state_t;
  state_t state, state_nx;
  logic [PW-1:0] pcnt, pcnt_nx, pinc;
  logic take, inc_t, inc_f, mis;
  assign mis = in_a != in_b;
  assign pinc = pcnt + 1'b1;
  // enable=0 takes priority over any beat while checking (MONITOR/SUSPECT)
  always_comb begin
    state_nx = state;
    pcnt_nx = pcnt;
    take = 1'b0;
    inc_t = 1'b0;
    inc_f = 1'b0;
    case (state)
      IDLE: begin
        take = valid;
        state_nx = enable ? MONITOR : IDLE;
      end
      MONITOR: begin
        if (!enable) state_nx = IDLE;
        else if (valid && !mis) take = 1'b1;
        else if (valid) begin
          pcnt_nx = PW'(1);
          inc_f = PERSIST == 1;
          state_nx = PERSIST == 1 ? ALARM : SUSPECT;
        end
      end
      SUSPECT: begin
        if (!enable) begin
          state_nx = IDLE;
          pcnt_nx = '0;
        end else if (valid && !mis) begin
          take = 1'b1;
          inc_t = 1'b1;
          pcnt_nx = '0;
          state_nx = MONITOR;
        end else if (valid) begin
          pcnt_nx = pinc;
          inc_f = pinc == PW'(PERSIST);
          state_nx = inc_f ? ALARM : SUSPECT;
        end
      end
      ALARM: begin
        if (clear) begin
          pcnt_nx = '0;
          state_nx = MONITOR;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pcnt <= '0;
      out <= '0;
      alarm <= 1'b0;
      transient_count <= '0;
      fault_count <= '0;
    end else begin
      state <= state_nx;
      pcnt <= pcnt_nx;
      alarm <= state_nx == ALARM;
      if (take) out <= in_a;
      if (inc_t && !(&transient_count)) transient_count <= transient_count + 1'b1;
      if (inc_f && !(&fault_count)) fault_count <= fault_count + 1'b1;
    end
  end
`ifdef GLITCH_DETECTOR_SYNDROME_EN
  always_ff @(posedge clk) begin
    if (reset) syndrome <= '0;
    else if (state == MONITOR && enable && valid && mis) syndrome <= in_a ^ in_b;
  end
`else
  assign syndrome = '0;
`endif
endmodule

// File: tb/tb_glitch_detector.sv
// tb_glitch_detector: directed scenarios plus randomized run against a streak-based reference model.
module tb_glitch_detector;
  localparam int BL = 8;
  localparam int PERSIST = 2;
  localparam int CNT_W = 8;
  localparam int MAXC = (1 << CNT_W) - 1;
  logic clk = 0, reset = 1, enable = 0, valid = 0, clear = 0;
  logic [BL-1:0] in_a = 0, in_b = 0, out, syndrome;
  logic alarm;
  logic [CNT_W-1:0] transient_count, fault_count;
  int n_checks = 0, n_fail = 0;
  bit m_active, m_alarm;
  int m_streak, m_tc, m_fc;
  logic [BL-1:0] m_out, m_syn, exp_syn;

  glitch_detector #(.BIT_LENGTH(BL), .PERSIST(PERSIST), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .valid(valid), .in_a(in_a), .in_b(in_b),
    .clear(clear), .out(out), .alarm(alarm), .transient_count(transient_count),
    .fault_count(fault_count), .syndrome(syndrome));

  always #5 clk = ~clk;

  // Model: "active" means checking is on, "streak" counts consecutive mismatching beats.
  task automatic model();
    if (reset) begin
      m_active = 0; m_alarm = 0; m_streak = 0; m_out = 0; m_tc = 0; m_fc = 0; m_syn = 0;
    end else if (m_alarm) begin
      if (clear) begin m_alarm = 0; m_streak = 0; m_active = 1; end
    end else if (!m_active) begin
      if (valid) m_out = in_a;
      if (enable) m_active = 1;
    end else if (!enable) begin
      m_active = 0; m_streak = 0;
    end else if (valid) begin
      if (in_a == in_b) begin
        if (m_streak > 0 && m_tc < MAXC) m_tc++;
        m_streak = 0;
        m_out = in_a;
      end else begin
`ifdef GLITCH_DETECTOR_SYNDROME_EN
        if (m_streak == 0) m_syn = in_a ^ in_b;
`endif
        m_streak++;
        if (m_streak == PERSIST) begin
          m_alarm = 1;
          if (m_fc < MAXC) m_fc++;
        end
      end
    end
  endtask

  task automatic step(input bit en, input bit v, input logic [BL-1:0] a, input logic [BL-1:0] b,
                      input bit clr, input bit rst);
    enable = en; valid = v; in_a = a; in_b = b; clear = clr; reset = rst;
    @(posedge clk);
    model();
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 8'hA5, 8'h5A, 1, 1);
    n_checks++;
    if (out !== 0 || alarm !== 0 || transient_count !== 0 || fault_count !== 0 || syndrome !== 0) begin
      n_fail++;
      $display("FAIL reset: out=%h alarm=%b tc=%0d fc=%0d syn=%h, required all zero",
               out, alarm, transient_count, fault_count, syndrome);
    end
  endtask

  task automatic test_match();
    step(1, 1, 8'h5A, 8'h5A, 0, 0);
    n_checks++;
    if (out !== 8'h5A) begin n_fail++; $display("FAIL match_first: out=%h required 5a", out); end
    for (int i = 0; i < 3; i++) step(1, 1, 8'h5A, 8'h5A, 0, 0);
    n_checks++;
    if (out !== 8'h5A || alarm !== 0 || transient_count !== 0 || fault_count !== 0) begin
      n_fail++;
      $display("FAIL match: out=%h alarm=%b tc=%0d fc=%0d, required 5a 0 0 0", out, alarm, transient_count, fault_count);
    end
  endtask

  task automatic test_transient();
    step(1, 1, 8'h5A, 8'h5B, 0, 0);
    n_checks++;
    if (out !== 8'h5A || alarm !== 0 || transient_count !== 0) begin
      n_fail++; $display("FAIL transient_hold: out=%h alarm=%b tc=%0d, required 5a 0 0", out, alarm, transient_count);
    end
    step(1, 1, 8'h3C, 8'h3C, 0, 0);
    n_checks++;
    if (out !== 8'h3C || alarm !== 0 || transient_count !== 1) begin
      n_fail++; $display("FAIL transient: out=%h alarm=%b tc=%0d, required 3c 0 1", out, alarm, transient_count);
    end
  endtask

  task automatic test_fault();
    step(1, 1, 8'h11, 8'h11, 0, 0);
    step(1, 1, 8'h5A, 8'h5B, 0, 0);
    n_checks++;
    if (alarm !== 0) begin n_fail++; $display("FAIL fault_early: alarm=%b required 0", alarm); end
    step(1, 1, 8'h5A, 8'h5B, 0, 0);
`ifdef GLITCH_DETECTOR_SYNDROME_EN
    exp_syn = 8'h01;
`else
    exp_syn = 8'h00;
`endif
    n_checks++;
    if (alarm !== 1 || fault_count !== 1 || out !== 8'h11 || syndrome !== exp_syn) begin
      n_fail++;
      $display("FAIL fault: alarm=%b fc=%0d out=%h syn=%h, required 1 1 11 %h", alarm, fault_count, out, syndrome, exp_syn);
    end
  endtask

  task automatic test_alarm_handling();
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'(i), 8'(i + 1), 0, 0);
      n_checks++;
      if (alarm !== 1 || fault_count !== 1 || out !== 8'h11) begin
        n_fail++; $display("FAIL alarm_hold[%0d]: alarm=%b fc=%0d out=%h, required 1 1 11", i, alarm, fault_count, out);
      end
    end
    step(1, 1, 8'h77, 8'h70, 1, 0);
    n_checks++;
    if (alarm !== 0 || fault_count !== 1 || transient_count !== 1 || out !== 8'h11) begin
      n_fail++;
      $display("FAIL alarm_clear: alarm=%b fc=%0d tc=%0d out=%h, required 0 1 1 11", alarm, fault_count, transient_count, out);
    end
    step(1, 1, 8'h44, 8'h45, 0, 0);
    n_checks++;
    if (out !== 8'h11) begin n_fail++; $display("FAIL clear_to_monitor: out=%h required 11", out); end
    step(1, 1, 8'h22, 8'h22, 0, 0);
    n_checks++;
    if (out !== 8'h22 || transient_count !== 2 || alarm !== 0) begin
      n_fail++; $display("FAIL post_clear: out=%h tc=%0d alarm=%b, required 22 2 0", out, transient_count, alarm);
    end
  endtask

  task automatic test_reset_in_suspect();
    step(1, 1, 8'h30, 8'h31, 0, 0);
    step(1, 1, 8'h30, 8'h31, 0, 1);
    n_checks++;
    if (out !== 0 || alarm !== 0 || transient_count !== 0 || fault_count !== 0 || syndrome !== 0) begin
      n_fail++;
      $display("FAIL reset_suspect: out=%h alarm=%b tc=%0d fc=%0d syn=%h, required all zero",
               out, alarm, transient_count, fault_count, syndrome);
    end
    step(1, 1, 8'h10, 8'h10, 0, 0);
    step(1, 1, 8'h10, 8'h11, 0, 0);
    step(1, 1, 8'h12, 8'h12, 0, 0);
    n_checks++;
    if (transient_count !== 1 || alarm !== 0 || fault_count !== 0 || out !== 8'h12) begin
      n_fail++;
      $display("FAIL after_reset: tc=%0d alarm=%b fc=%0d out=%h, required 1 0 0 12", transient_count, alarm, fault_count, out);
    end
  endtask

  task automatic test_saturation();
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < MAXC + 5; i++) begin
      step(1, 1, 8'h0F, 8'h1F, 0, 0);
      step(1, 1, 8'h0F, 8'h0F, 0, 0);
      if (i == MAXC - 2) begin
        n_checks++;
        if (transient_count !== CNT_W'(MAXC - 1)) begin
          n_fail++; $display("FAIL sat_below: tc=%0d required %0d", transient_count, MAXC - 1);
        end
      end
    end
    n_checks++;
    if (transient_count !== CNT_W'(MAXC) || alarm !== 0) begin
      n_fail++; $display("FAIL saturation: tc=%0d alarm=%b, required %0d 0", transient_count, alarm, MAXC);
    end
  endtask

  task automatic test_random();
    logic [BL-1:0] a, b;
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2000; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 9) < 6) ? a : 8'($urandom);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, a, b,
           $urandom_range(0, 4) == 0, $urandom_range(0, 99) == 0);
      n_checks++;
      if (out !== m_out || alarm !== m_alarm || transient_count !== CNT_W'(m_tc) ||
          fault_count !== CNT_W'(m_fc) || syndrome !== m_syn) begin
        n_fail++;
        $display("FAIL random[%0d]: out=%h alarm=%b tc=%0d fc=%0d syn=%h, required %h %b %0d %0d %h",
                 i, out, alarm, transient_count, fault_count, syndrome, m_out, m_alarm, m_tc, m_fc, m_syn);
      end
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_transient();
    test_fault();
    test_alarm_handling();
    test_reset_in_suspect();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
